// File: rtl/ghost_target_gen_pkg.sv
// ghost_target_gen_pkg: shared types, grid limits, scatter corners and schedule for ghost targeting.
package ghost_target_gen_pkg;
   typedef enum logic [1:0] {SCATTER = 2'd0, CHASE = 2'd1, FRIGHT = 2'd2} mode_t;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;
   localparam int GRID_ROWS = 31;
   localparam int GRID_COLS = 28;
   localparam logic [4:0] ROW_LAST = 5'(GRID_ROWS - 1);
   localparam logic [4:0] COL_LAST = 5'(GRID_COLS - 1);
   localparam logic [9:0] CORNER_BLINKY = {5'd30, 5'd27};
   localparam logic [9:0] CORNER_PINKY  = {5'd30, 5'd0};
   localparam logic [9:0] CORNER_INKY   = {5'd0, 5'd27};
   localparam logic [9:0] CORNER_CLYDE  = {5'd0, 5'd0};
   // Phase 7 runs forever, so its entry is never consulted.
   localparam logic [10:0] SCHED_TICKS [8] = '{11'd420, 11'd1200, 11'd420, 11'd1200,
                                               11'd300, 11'd1200, 11'd300, 11'd0};
   function automatic logic [4:0] clamp(input logic signed [7:0] v, input logic [4:0] hi);
      return (v < 8'sd0) ? 5'd0 : (v > $signed({3'b000, hi})) ? hi : v[4:0];
   endfunction
   function automatic logic [9:0] fright_tile(input logic [9:0] v);
      return {(v[4:0] > ROW_LAST) ? ROW_LAST : v[4:0], (v[9:5] > COL_LAST) ? COL_LAST : v[9:5]};
   endfunction
endpackage

// File: rtl/ghost_mode_timer.sv
// ghost_mode_timer: scatter/chase schedule plus frightened countdown; while frightened the
// schedule is frozen, so the held phase is the saved mode restored on expiry.
module ghost_mode_timer
   import ghost_target_gen_pkg::*;
#(
   parameter int TICKS_FRIGHT = 360
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_tick,
   input  logic  i_start,
   input  logic  i_energizer,
   output mode_t o_mode,
   output logic  o_flip
);
   localparam int FW = $clog2(TICKS_FRIGHT + 1);
   logic [2:0]    r_phase;
   logic [10:0]   r_timer;
   logic [FW-1:0] r_fcnt;
   logic          r_fright;
   logic          r_flip;
   logic          w_expire;
   assign w_expire = (r_phase != 3'd7) && (r_timer + 11'd1 == SCHED_TICKS[r_phase]);
   assign o_mode   = r_fright ? FRIGHT : r_phase[0] ? CHASE : SCATTER;
   assign o_flip   = r_flip;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= '0;
         r_timer  <= '0;
         r_fcnt   <= '0;
         r_fright <= 1'b0;
         r_flip   <= 1'b0;
      end else begin
         r_flip <= 1'b0;
         if (i_tick) begin
            if (i_start) begin
               r_phase  <= '0;
               r_timer  <= '0;
               r_fcnt   <= '0;
               r_fright <= 1'b0;
            end else if (r_fright) begin
               r_fcnt   <= i_energizer ? FW'(TICKS_FRIGHT) : r_fcnt - 1'b1;
               r_fright <= i_energizer || (r_fcnt != FW'(1));
            end else begin
               // The schedule steps first, so an energizer on an expiry tick saves the new phase.
               r_phase  <= r_phase + {2'b00, w_expire};
               r_timer  <= w_expire ? 11'd0 : r_timer + {10'd0, r_phase != 3'd7};
               r_fright <= i_energizer;
               r_fcnt   <= i_energizer ? FW'(TICKS_FRIGHT) : r_fcnt;
               r_flip   <= w_expire || i_energizer;
            end
         end
      end
   end
endmodule

// File: rtl/ghost_target_gen.sv
// ghost_target_gen: two-stage per-frame target tile generator for the four ghosts.
// Stage 1 snapshots positions and steps mode/LFSR; stage 2 computes targets from the snapshot.
module ghost_target_gen
   import ghost_target_gen_pkg::*;
#(
   parameter int          TICKS_FRIGHT = 360,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_game_tick,
   input  logic       i_game_start,
   input  logic       i_energizer,
   input  logic [9:0] i_pacman_tile,
   input  dir_t       i_pacman_dir,
   input  logic [9:0] i_blinky_tile,
   input  logic [9:0] i_clyde_tile,
   output logic [9:0] o_target_blinky,
   output logic [9:0] o_target_pinky,
   output logic [9:0] o_target_inky,
   output logic [9:0] o_target_clyde,
   output mode_t      o_ghost_mode,
   output logic       o_mode_flip,
   output logic       o_targets_valid
);
   logic [15:0]        r_lfsr;
   logic [9:0]         r_pac, r_blinky, r_clyde;
   dir_t               r_dir;
   logic               r_v1, r_valid;
   logic [9:0]         r_tb, r_tp, r_ti, r_tc;
   mode_t              w_mode;
   logic signed [7:0]  w_pr, w_pc, w_br, w_bc, w_cr, w_cc, w_ur, w_uc, w_ar, w_ac, w_dr, w_dc;
   logic signed [10:0] w_dr_x, w_dc_x;
   logic [10:0]        w_dist;
   logic [9:0]         w_ch_b, w_ch_p, w_ch_i, w_ch_c;
   ghost_mode_timer #(.TICKS_FRIGHT(TICKS_FRIGHT)) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_tick      (i_game_tick),
      .i_start     (i_game_start),
      .i_energizer (i_energizer),
      .o_mode      (w_mode),
      .o_flip      (o_mode_flip)
   );
   assign w_pr   = $signed({3'b000, r_pac[9:5]});
   assign w_pc   = $signed({3'b000, r_pac[4:0]});
   assign w_br   = $signed({3'b000, r_blinky[9:5]});
   assign w_bc   = $signed({3'b000, r_blinky[4:0]});
   assign w_cr   = $signed({3'b000, r_clyde[9:5]});
   assign w_cc   = $signed({3'b000, r_clyde[4:0]});
   assign w_ur   = (r_dir == DIR_UP) ? 8'sd1 : (r_dir == DIR_DOWN) ? -8'sd1 : 8'sd0;
   assign w_uc   = (r_dir == DIR_RIGHT) ? 8'sd1 : (r_dir == DIR_LEFT) ? -8'sd1 : 8'sd0;
   assign w_ar   = w_pr + 8'sd2 * w_ur;
   assign w_ac   = w_pc + 8'sd2 * w_uc;
   assign w_dr   = w_cr - w_pr;
   assign w_dc   = w_cc - w_pc;
   assign w_dr_x = {{3{w_dr[7]}}, w_dr};
   assign w_dc_x = {{3{w_dc[7]}}, w_dc};
   assign w_dist = w_dr_x * w_dr_x + w_dc_x * w_dc_x;
   assign w_ch_b = {clamp(w_pr, ROW_LAST), clamp(w_pc, COL_LAST)};
   assign w_ch_p = {clamp(w_pr + 8'sd4 * w_ur, ROW_LAST), clamp(w_pc + 8'sd4 * w_uc, COL_LAST)};
   assign w_ch_i = {clamp(8'sd2 * w_ar - w_br, ROW_LAST), clamp(8'sd2 * w_ac - w_bc, COL_LAST)};
   assign w_ch_c = (w_dist >= 11'd64) ? w_ch_b : CORNER_CLYDE;
   assign o_ghost_mode    = w_mode;
   assign o_targets_valid = r_valid;
   assign o_target_blinky = r_tb;
   assign o_target_pinky  = r_tp;
   assign o_target_inky   = r_ti;
   assign o_target_clyde  = r_tc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr   <= LFSR_SEED;
         r_pac    <= '0;
         r_blinky <= '0;
         r_clyde  <= '0;
         r_dir    <= DIR_UP;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= i_game_tick;
         if (i_game_tick) begin
            r_lfsr   <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            r_pac    <= i_pacman_tile;
            r_dir    <= i_pacman_dir;
            r_blinky <= i_blinky_tile;
            r_clyde  <= i_clyde_tile;
         end
      end
   end
   // Frightened targets take the low 10 bits of the LFSR rotated left by 0/4/8/12.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tb    <= CORNER_BLINKY;
         r_tp    <= CORNER_PINKY;
         r_ti    <= CORNER_INKY;
         r_tc    <= CORNER_CLYDE;
      end else begin
         r_valid <= r_v1;
         if (r_v1) begin
            r_tb <= (w_mode == FRIGHT) ? fright_tile(r_lfsr[9:0]) : (w_mode == CHASE) ? w_ch_b : CORNER_BLINKY;
            r_tp <= (w_mode == FRIGHT) ? fright_tile({r_lfsr[5:0], r_lfsr[15:12]}) : (w_mode == CHASE) ? w_ch_p : CORNER_PINKY;
            r_ti <= (w_mode == FRIGHT) ? fright_tile({r_lfsr[1:0], r_lfsr[15:8]}) : (w_mode == CHASE) ? w_ch_i : CORNER_INKY;
            r_tc <= (w_mode == FRIGHT) ? fright_tile(r_lfsr[13:4]) : (w_mode == CHASE) ? w_ch_c : CORNER_CLYDE;
         end
      end
   end
endmodule

// File: tb/tb_ghost_target_gen.sv
// tb_ghost_target_gen: directed stimulus with a target scoreboard and per-tick mode checks.
module tb_ghost_target_gen;
   import ghost_target_gen_pkg::*;
   typedef struct {
      logic [9:0] b, p, i, c;
      int         due;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_game_tick = 1'b0, i_game_start = 1'b0, i_energizer = 1'b0;
   logic [9:0] i_pacman_tile = '0, i_blinky_tile = '0, i_clyde_tile = '0;
   dir_t       i_pacman_dir = DIR_UP;
   logic [9:0] o_target_blinky, o_target_pinky, o_target_inky, o_target_clyde;
   mode_t      o_ghost_mode;
   logic       o_mode_flip, o_targets_valid;
   int         checks = 0, errors = 0, cyc = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   exp_t       sb[$];
   exp_t       e_m;

   ghost_target_gen dut (
      .clk(clk), .rst_n(rst_n), .i_game_tick(i_game_tick), .i_game_start(i_game_start),
      .i_energizer(i_energizer), .i_pacman_tile(i_pacman_tile), .i_pacman_dir(i_pacman_dir),
      .i_blinky_tile(i_blinky_tile), .i_clyde_tile(i_clyde_tile),
      .o_target_blinky(o_target_blinky), .o_target_pinky(o_target_pinky),
      .o_target_inky(o_target_inky), .o_target_clyde(o_target_clyde),
      .o_ghost_mode(o_ghost_mode), .o_mode_flip(o_mode_flip), .o_targets_valid(o_targets_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [9:0] tile(input int r, input int c);
      logic [4:0] rr, cc;
      rr = (r < 0) ? 5'd0 : (r > 30) ? 5'd30 : 5'(r);
      cc = (c < 0) ? 5'd0 : (c > 27) ? 5'd27 : 5'(c);
      return {rr, cc};
   endfunction

   function automatic logic [9:0] ft(input logic [15:0] v, input int k);
      logic [31:0] w;
      logic [4:0]  rr, cc;
      w  = {v, v} << k;
      rr = (w[20:16] > 5'd30) ? 5'd30 : w[20:16];
      cc = (w[25:21] > 5'd27) ? 5'd27 : w[25:21];
      return {rr, cc};
   endfunction

   function automatic exp_t model(input mode_t m, input logic [15:0] l, input logic [9:0] pac,
                                  input dir_t d, input logic [9:0] bl, input logic [9:0] cl);
      exp_t e;
      int pr, pc, ur, uc, br, bc, cr, cc;
      pr = int'(pac[9:5]); pc = int'(pac[4:0]);
      br = int'(bl[9:5]);  bc = int'(bl[4:0]);
      cr = int'(cl[9:5]);  cc = int'(cl[4:0]);
      ur = (d == DIR_UP) ? 1 : (d == DIR_DOWN) ? -1 : 0;
      uc = (d == DIR_RIGHT) ? 1 : (d == DIR_LEFT) ? -1 : 0;
      e.due = 0;
      if (m == FRIGHT) begin
         e.b = ft(l, 0); e.p = ft(l, 4); e.i = ft(l, 8); e.c = ft(l, 12);
      end else if (m == CHASE) begin
         e.b = tile(pr, pc);
         e.p = tile(pr + 4 * ur, pc + 4 * uc);
         e.i = tile(2 * (pr + 2 * ur) - br, 2 * (pc + 2 * uc) - bc);
         e.c = ((cr - pr) * (cr - pr) + (cc - pc) * (cc - pc) >= 64) ? tile(pr, pc) : 10'd0;
      end else begin
         e.b = {5'd30, 5'd27}; e.p = {5'd30, 5'd0}; e.i = {5'd0, 5'd27}; e.c = 10'd0;
      end
      return e;
   endfunction

   task automatic tick(input logic st, input logic en, input mode_t em, input logic ef);
      exp_t e;
      i_game_tick = 1'b1; i_game_start = st; i_energizer = en;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      e = model(em, m_lfsr, i_pacman_tile, i_pacman_dir, i_blinky_tile, i_clyde_tile);
      e.due = cyc + 2;
      sb.push_back(e);
      @(posedge clk); #1;
      i_game_tick = 1'b0; i_game_start = 1'b0; i_energizer = 1'b0;
      chk("ghost_mode", o_ghost_mode, em);
      chk("mode_flip", o_mode_flip, ef);
   endtask

   task automatic chk_reset();
      chk("rst_blinky", o_target_blinky, {5'd30, 5'd27});
      chk("rst_pinky", o_target_pinky, {5'd30, 5'd0});
      chk("rst_inky", o_target_inky, {5'd0, 5'd27});
      chk("rst_clyde", o_target_clyde, 10'd0);
      chk("rst_mode", o_ghost_mode, SCATTER);
      chk("rst_flip", o_mode_flip, 1'b0);
      chk("rst_valid", o_targets_valid, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst_n && o_targets_valid) begin
         if (sb.size() == 0) chk("spurious_valid", o_targets_valid, 1'b0);
         else begin
            e_m = sb.pop_front();
            chk("valid_latency", cyc, e_m.due);
            chk("t_blinky", o_target_blinky, e_m.b);
            chk("t_pinky", o_target_pinky, e_m.p);
            chk("t_inky", o_target_inky, e_m.i);
            chk("t_clyde", o_target_clyde, e_m.c);
         end
      end else if (rst_n && sb.size() != 0 && cyc >= sb[0].due) begin
         chk("valid_missing", o_targets_valid, 1'b1);
         void'(sb.pop_front());
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      i_pacman_tile = {5'd10, 5'd5}; i_pacman_dir = DIR_UP;
      i_blinky_tile = {5'd8, 5'd5};  i_clyde_tile = {5'd20, 5'd20};
      for (int k = 1; k < 420; k++) tick(1'b0, 1'b0, SCATTER, 1'b0);
      tick(1'b0, 1'b0, CHASE, 1'b1);
      i_pacman_tile = {5'd28, 5'd26}; i_pacman_dir = DIR_RIGHT; i_blinky_tile = 10'd0;
      tick(1'b0, 1'b0, CHASE, 1'b0);
      i_clyde_tile = {5'd10, 5'd10}; i_pacman_tile = {5'd10, 5'd17};
      tick(1'b0, 1'b0, CHASE, 1'b0);
      i_pacman_tile = {5'd10, 5'd18};
      tick(1'b0, 1'b0, CHASE, 1'b0);
      i_pacman_tile = 10'h3FF; i_blinky_tile = 10'h155; i_pacman_dir = DIR_DOWN;
      repeat (3) @(posedge clk);
      #1;
      i_energizer = 1'b1;
      @(posedge clk); #1;
      i_energizer = 1'b0;
      chk("untimed_energizer_mode", o_ghost_mode, CHASE);
      chk("untimed_energizer_flip", o_mode_flip, 1'b0);
      i_pacman_tile = {5'd1, 5'd1}; i_pacman_dir = DIR_DOWN; i_blinky_tile = {5'd30, 5'd27};
      tick(1'b0, 1'b0, CHASE, 1'b0);
      for (int k = 5; k < 100; k++) tick(1'b0, 1'b0, CHASE, 1'b0);
      tick(1'b0, 1'b1, FRIGHT, 1'b1);
      for (int k = 0; k < 199; k++) tick(1'b0, 1'b0, FRIGHT, 1'b0);
      tick(1'b0, 1'b1, FRIGHT, 1'b0);
      for (int k = 0; k < 359; k++) tick(1'b0, 1'b0, FRIGHT, 1'b0);
      tick(1'b0, 1'b0, CHASE, 1'b0);
      for (int k = 0; k < 1099; k++) tick(1'b0, 1'b0, CHASE, 1'b0);
      tick(1'b0, 1'b0, SCATTER, 1'b1);
      tick(1'b0, 1'b1, FRIGHT, 1'b1);
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, FRIGHT, 1'b0);
      tick(1'b1, 1'b1, SCATTER, 1'b0);
      for (int k = 1; k < 420; k++) tick(1'b0, 1'b0, SCATTER, 1'b0);
      tick(1'b0, 1'b0, CHASE, 1'b1);
      for (int k = 1; k < 1200; k++) tick(1'b0, 1'b0, CHASE, 1'b0);
      tick(1'b0, 1'b1, FRIGHT, 1'b1);
      for (int k = 0; k < 359; k++) tick(1'b0, 1'b0, FRIGHT, 1'b0);
      tick(1'b0, 1'b0, SCATTER, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      tick(1'b0, 1'b0, SCATTER, 1'b0);
      rst_n = 1'b0;
      #2;
      sb.delete();
      m_lfsr = 16'hACE1;
      chk_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_valid", o_targets_valid, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, SCATTER, 1'b0);
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
      #1;
      chk("scoreboard_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
